// File: rtl/adc_reader_pkg.sv
// adc_reader_pkg: shared types and default sizing for the serial-ADC frame reader.
//   state_t      - reader FSM states
//   DEF_*        - default parameter values for adc_frame_reader
//   IDX_W        - width of the accepted-sample counter
//   cnt_w()      - counter width able to hold 0..n-1 (never narrower than 1 bit)
package adc_reader_pkg;

  localparam int unsigned DEF_DATA_W     = 12;
  localparam int unsigned DEF_FRAME_BITS = 16;
  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_QUIET_CYC  = 4;
  localparam int unsigned IDX_W          = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    SHIFT    = 2'd2,
    QUIET    = 2'd3
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: half-period divider producing the ADC serial clock.
//   clk, rst  - system clock, async active-low reset
//   load      - start a burst: sclk driven low, divider restarted
//   run       - keep dividing; when neither load nor run, sclk idles high
//   sclk      - registered serial clock
//   rise_c    - this clk edge drives sclk 0->1 (data sampling edge)
//   fall_c    - this clk edge ends a high phase
module adc_sclk_gen
  import adc_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = cnt_w(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             phase_end;

  // Strobes come from registered state only, so the FSM can use them
  // to decide its next state without a combinational loop through run.
  assign phase_end = (cnt == CNT_W'(CLK_DIV - 1));
  assign rise_c    = phase_end & ~sclk;
  assign fall_c    = phase_end & sclk;

  // Divider counter and serial clock register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (load) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (run) begin
      if (phase_end) begin
        cnt  <= '0;
        sclk <= ~sclk;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt  <= '0;
      sclk <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_reader.sv
// adc_frame_reader: reads conversion frames from a serial ADC and presents
// each sample through a one-entry valid/ready buffer.
//   clk, rst           - system clock, async active-low reset
//   enable             - continuous conversions while high
//   adc_sdata          - serial data from the ADC (MSB first)
//   adc_cs_n, adc_sclk - registered chip select / serial clock to the ADC
//   sample_data/valid  - buffered sample, held until sample_ready
//   sample_ready       - downstream accept
//   sample_index       - count of accepted samples (wraps)
//   frame_err          - sticky: a leading non-data bit read as 1
//   overrun            - sticky: a frame completed while the buffer was full
//   clr_flags          - clears both sticky flags (a same-cycle set wins)
module adc_frame_reader
  import adc_reader_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned QUIET_CYC  = DEF_QUIET_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              adc_sdata,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [IDX_W-1:0]  sample_index,
  output logic              frame_err,
  output logic              overrun,
  input  logic              clr_flags
);

  localparam int unsigned BIT_W = cnt_w(FRAME_BITS + 1);
  localparam int unsigned CYC_W = cnt_w((CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC);

  state_t                state;
  state_t                state_nx;
  logic [CYC_W-1:0]      cyc_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;

  logic sclk_rise_c;
  logic sclk_fall_c;
  logic sclk_load_c;
  logic sclk_run_c;
  logic shift_c;
  logic frame_done_c;
  logic accept_c;
  logic lead_err_c;
  logic ovr_set_c;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (sclk_load_c),
    .run    (sclk_run_c),
    .sclk   (adc_sclk),
    .rise_c (sclk_rise_c),
    .fall_c (sclk_fall_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nx     = state;
    sclk_load_c  = 1'b0;
    sclk_run_c   = 1'b0;
    shift_c      = 1'b0;
    frame_done_c = 1'b0;
    accept_c     = sample_valid & sample_ready;
    lead_err_c   = 1'b0;
    ovr_set_c    = 1'b0;

    case (state)
      IDLE:     if (enable) state_nx = CS_SETUP;
      CS_SETUP: if (cyc_cnt == CYC_W'(CLK_DIV - 1)) state_nx = SHIFT;
      // The frame ends at the close of the last high phase, sclk left high.
      SHIFT:    if (sclk_fall_c && (bit_cnt == BIT_W'(FRAME_BITS))) state_nx = QUIET;
      QUIET:    if (cyc_cnt == CYC_W'(QUIET_CYC - 1)) state_nx = enable ? CS_SETUP : IDLE;
      default:  state_nx = IDLE;
    endcase

    sclk_load_c  = (state != SHIFT) && (state_nx == SHIFT);
    sclk_run_c   = (state == SHIFT) && (state_nx == SHIFT);
    shift_c      = (state == SHIFT) && sclk_rise_c;
    frame_done_c = (state == SHIFT) && (state_nx == QUIET);
    lead_err_c   = frame_done_c && ((shreg >> DATA_W) != '0);
    ovr_set_c    = frame_done_c && sample_valid && !accept_c;
  end

  // Phase timer for CS_SETUP and QUIET, restarted on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                        cyc_cnt <= '0;
    else if (state_nx != state)                      cyc_cnt <= '0;
    else if ((state == CS_SETUP) || (state == QUIET)) cyc_cnt <= cyc_cnt + CYC_W'(1);
  end

  // Bit counter and deserialiser, sampled on the edge that raises sclk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sclk_load_c) begin
      bit_cnt <= '0;
    end else if (shift_c) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
      shreg   <= {shreg[FRAME_BITS-2:0], adc_sdata};
    end
  end

  // Chip select follows the state being entered so it is registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) adc_cs_n <= 1'b1;
    else      adc_cs_n <= ~((state_nx == CS_SETUP) || (state_nx == SHIFT));
  end

  // One-entry output buffer; a full buffer drops the new sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      sample_index <= '0;
    end else begin
      if (frame_done_c && (!sample_valid || accept_c)) begin
        sample_data  <= shreg[DATA_W-1:0];
        sample_valid <= 1'b1;
      end else if (accept_c) begin
        sample_valid <= 1'b0;
      end
      if (accept_c) sample_index <= sample_index + IDX_W'(1);
    end
  end

  // Sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= lead_err_c | (frame_err & ~clr_flags);
      overrun   <= ovr_set_c  | (overrun   & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// tb_adc_frame_reader: bench for adc_frame_reader with a behavioural ADC,
// a frame-level reference model of the output buffer, a vector table and
// hand-written sequences for multi-cycle corner cases.
module tb_adc_frame_reader;
  import adc_reader_pkg::*;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned FB        = 16;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned QUIET_CYC = 4;
  localparam int unsigned LOW_CYC   = CLK_DIV + 2 * CLK_DIV * FB;
  localparam int unsigned N_TBL     = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              adc_sdata;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic [15:0]       sample_index;
  logic              frame_err;
  logic              overrun;
  logic              clr_flags;

  always #5 clk = ~clk;

  adc_frame_reader #(
    .DATA_W(DATA_W), .FRAME_BITS(FB), .CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_sdata(adc_sdata),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_index(sample_index), .frame_err(frame_err), .overrun(overrun),
    .clr_flags(clr_flags)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL timeout %s (t=%0t)", name, $time);
  endtask

  // Behavioural ADC: latches a word when selected, shifts a new bit out on
  // every falling sclk. A frame counts as delivered when cs_n rises after
  // all FB bits were clocked.
  logic [FB-1:0] next_word = '0;
  logic [FB-1:0] cur_word  = '0;
  int            fall_cnt  = 0;
  bit            done_ev   = 1'b0;

  always @(negedge adc_cs_n) begin
    cur_word = next_word;
    fall_cnt = 0;
  end

  always @(negedge adc_sclk) begin
    if (adc_cs_n === 1'b0) begin
      if (fall_cnt < int'(FB)) adc_sdata = cur_word[FB-1-fall_cnt];
      fall_cnt++;
    end
  end

  always @(posedge adc_cs_n) begin
    if (fall_cnt == int'(FB)) done_ev = 1'b1;
    fall_cnt = 0;
  end

  // Reference model of the sample buffer, updated once per clock edge
  bit                m_valid;
  logic [DATA_W-1:0] m_data;
  int unsigned       m_index;
  bit                m_err;
  bit                m_ovr;
  bit                chk_on = 1'b0;

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_index = 0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    done_ev = 1'b0;
  endtask

  always @(posedge clk) begin
    bit r, c, rs, acc, e_set, o_set;
    r  = sample_ready;
    c  = clr_flags;
    rs = rst;
    #1;
    if (!rs) begin
      model_reset();
    end else begin
      acc   = m_valid && r;
      e_set = 1'b0;
      o_set = 1'b0;
      if (done_ev) begin
        done_ev = 1'b0;
        e_set   = (cur_word >> DATA_W) != 0;
        if (!m_valid || acc) begin
          m_data  = cur_word[DATA_W-1:0];
          m_valid = 1'b1;
        end else begin
          o_set = 1'b1;
        end
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (acc) m_index = (m_index + 1) % 65536;
      m_err = e_set || (m_err && !c);
      m_ovr = o_set || (m_ovr && !c);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_valid", sample_valid, m_valid);
      chk("model_index", sample_index, m_index[15:0]);
      chk("model_frame_err", frame_err, m_err);
      chk("model_overrun", overrun, m_ovr);
      if (m_valid) chk("model_data", sample_data, m_data);
    end
  end

  // Bounded waits, all resuming on a falling clk edge
  task automatic wait_frame_start(input string tag);
    bit seen_high;
    seen_high = adc_cs_n;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (adc_cs_n) seen_high = 1'b1;
      else if (seen_high) return;
    end
    timeout({"frame_start ", tag});
  endtask

  task automatic wait_cs_high(input string tag);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (adc_cs_n) return;
    end
    timeout({"cs_high ", tag});
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (sample_valid) return;
    end
    timeout({"valid ", tag});
  endtask

  task automatic wait_rises(input int k, input string tag);
    logic prev;
    int   seen;
    prev = adc_sclk;
    seen = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (adc_sclk && !prev) seen++;
      prev = adc_sclk;
      if (seen >= k) return;
    end
    timeout({"sclk_rises ", tag});
  endtask

  typedef struct {
    logic [15:0]       word;
    logic [DATA_W-1:0] data;
    bit                err;
    bit                clr;
  } vec_t;

  vec_t tbl [N_TBL];

  initial begin
    int low, quiet, first_fall, viol;

    tbl[0] = '{16'h0ABC, 12'hABC, 1'b0, 1'b1};
    tbl[1] = '{16'h8123, 12'h123, 1'b1, 1'b1};
    tbl[2] = '{16'h0FFF, 12'hFFF, 1'b1, 1'b0};
    tbl[3] = '{16'h0000, 12'h000, 1'b0, 1'b1};
    tbl[4] = '{16'h1000, 12'h000, 1'b1, 1'b1};
    tbl[5] = '{16'hF555, 12'h555, 1'b1, 1'b1};
    tbl[6] = '{16'h0800, 12'h800, 1'b0, 1'b1};
    tbl[7] = '{16'h0001, 12'h001, 1'b0, 1'b1};

    rst = 1'b1; enable = 1'b0; adc_sdata = 1'b0; sample_ready = 1'b0; clr_flags = 1'b0;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1'b1);
    chk("rst_sclk", adc_sclk, 1'b1);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_data", sample_data, 12'h000);
    chk("rst_index", sample_index, 16'd0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst = 1'b1;
    chk_on = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_cs_n", adc_cs_n, 1'b1);

    // Frame timing with ready held high
    next_word = 16'h0ABC; sample_ready = 1'b1; enable = 1'b1;
    wait_frame_start("timing");
    low = 0; first_fall = -1;
    for (int i = 0; i < 200 && adc_cs_n == 1'b0; i++) begin
      if (!adc_sclk && first_fall < 0) first_fall = i;
      low++;
      @(negedge clk);
    end
    chk("cs_low_cycles", low, LOW_CYC);
    chk("first_sclk_fall", first_fall, CLK_DIV);
    chk("latency_valid", sample_valid, 1'b1);
    chk("latency_data", sample_data, 12'hABC);
    quiet = 0;
    for (int i = 0; i < 200 && adc_cs_n == 1'b1; i++) begin
      quiet++;
      @(negedge clk);
    end
    chk("quiet_cycles", quiet, QUIET_CYC);
    chk("index_after_first", sample_index, 16'd1);

    // Vector table: one frame per entry, consecutive frames
    for (int i = 0; i < int'(N_TBL); i++) begin
      next_word = tbl[i].word;
      wait_frame_start("table");
      if (tbl[i].clr) begin
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("tbl_err_cleared", frame_err, 1'b0);
      end
      wait_valid("table");
      chk("tbl_data", sample_data, tbl[i].data);
      chk("tbl_frame_err", frame_err, tbl[i].err);
      chk("tbl_index", sample_index, 16'(2 + i));
    end

    // Overrun: two frames complete with ready low
    next_word = 16'h0001;
    wait_frame_start("ovr1");
    sample_ready = 1'b0;
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    next_word = 16'h0002;
    wait_frame_start("ovr2");
    chk("ovr_first_held", sample_data, 12'h001);
    wait_cs_high("ovr2");
    @(negedge clk);
    chk("ovr_data_kept", sample_data, 12'h001);
    chk("ovr_valid", sample_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_index", sample_index, 16'(2 + N_TBL));
    next_word = 16'h0333;
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    chk("ovr_accept_valid", sample_valid, 1'b0);
    chk("ovr_accept_index", sample_index, 16'(3 + N_TBL));
    @(negedge clk);
    chk("ovr_accept_once", sample_index, 16'(3 + N_TBL));

    // Ready arrives exactly on the completion edge of the next frame
    wait_frame_start("same_cycle_a");
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);
    next_word = 16'h0444;
    wait_cs_high("same_cycle_a");
    @(negedge clk);
    chk("sc_first_data", sample_data, 12'h333);
    wait_frame_start("same_cycle_b");
    repeat (LOW_CYC - 1) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    chk("sc_cs_n", adc_cs_n, 1'b1);
    chk("sc_data", sample_data, 12'h444);
    chk("sc_valid", sample_valid, 1'b1);
    chk("sc_overrun", overrun, 1'b0);
    chk("sc_index", sample_index, 16'(4 + N_TBL));

    // enable dropped mid-frame
    next_word = 16'h0555;
    wait_frame_start("en_drop");
    wait_rises(5, "en_drop");
    enable = 1'b0;
    wait_valid("en_drop");
    chk("en_drop_data", sample_data, 12'h555);
    chk("en_drop_index", sample_index, 16'(5 + N_TBL));
    viol = 0;
    repeat (150) begin
      @(negedge clk);
      if (!adc_cs_n || !adc_sclk) viol++;
    end
    chk("en_drop_idle", viol, 0);

    // Reset in the middle of a frame
    sample_ready = 1'b0;
    next_word = 16'h0666;
    enable = 1'b1;
    wait_frame_start("rst_a");
    next_word = 16'h0777;
    wait_valid("rst_a");
    wait_frame_start("rst_b");
    wait_rises(8, "rst_b");
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("async_cs_n", adc_cs_n, 1'b1);
    chk("async_sclk", adc_sclk, 1'b1);
    chk("async_valid", sample_valid, 1'b0);
    chk("async_index", sample_index, 16'd0);
    @(negedge clk);
    next_word = 16'h0321;
    sample_ready = 1'b1;
    rst = 1'b1;
    wait_frame_start("rst_c");
    wait_valid("rst_c");
    chk("post_rst_data", sample_data, 12'h321);
    chk("post_rst_err", frame_err, 1'b0);

    // Random words, ready and clears, checked against the model
    for (int c = 0; c < 1400; c++) begin
      @(negedge clk);
      next_word    = ($urandom_range(0, 3) == 0) ? 16'($urandom) : {4'h0, 12'($urandom)};
      sample_ready = (c < 700) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
      clr_flags    = ($urandom_range(0, 19) == 0);
    end
    clr_flags = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
